bsx_flash_ctrl: RTL and testbench

- Command sequencer for the BS-X memory-pack flash window (banks C0-FF, 4 MB).
- Decodes SNES write sequences into read-array / ID / status / program / erase modes and drives the data override toward the SNES.
- Gates flash write-enable per program cycle.
- Hands block- and chip-erase jobs to the MCU through a req/ack handshake, reporting busy status until the MCU completes.

---
 rtl/bsx_flash_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bsx_flash_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bsx_flash_ctrl.sv
// BS-X memory-pack flash command sequencer.
// Decodes SNES command writes into the flash window (banks C0-FF) and tracks
// read-array / ID / status / program / erase modes. It provides override data
// for status and ID reads, gates pack write-enable for program cycles, and hands
// erase jobs to the MCU through a req/ack handshake.
module bsx_flash_ctrl #(
    parameter int          PROG_BUSY_CYCLES = 16,
    parameter logic [63:0] ID_BYTES         = 64'h001A00000050004D
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        use_bsx,
    input  logic        flash_wp_n,
    input  logic        reg_we_rising,
    input  logic        reg_oe_falling,
    input  logic [23:0] snes_addr,
    input  logic [7:0]  reg_data_in,
    output logic [7:0]  reg_data_out,
    output logic        data_ovr,
    output logic        flash_writable,
    output logic        busy,
    output logic        erase_req,
    output logic        erase_chip,
    output logic [5:0]  erase_block,
    input  logic        erase_ack
);

    localparam int CNT_W = (PROG_BUSY_CYCLES > 1) ? $clog2(PROG_BUSY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PROG_BUSY_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_ARRAY,
        ST_ID,
        ST_STATUS,
        ST_ERASE_SETUP,
        ST_PROG_ARMED,
        ST_PROG_BUSY,
        ST_ERASE_BUSY
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             erase_req_reg;
    logic             erase_chip_reg;
    logic [5:0]       erase_block_reg;
    logic [7:0]       data_out_reg;

    logic             in_flash;
    logic             cmd_wr;
    logic             rd_evt;
    logic [7:0]       read_value;
    logic [7:0]       id_rom [8];

    assign in_flash = use_bsx & (snes_addr[23:22] == 2'b11);
    assign cmd_wr   = reg_we_rising & in_flash & flash_wp_n;
    // A write strobe in the same cycle wins over a read strobe.
    assign rd_evt   = reg_oe_falling & in_flash & ~reg_we_rising;

    // Split the packed vendor/device constant into per-offset bytes.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_id_rom
            assign id_rom[gi] = ID_BYTES[gi*8 +: 8];
        end
    endgenerate

    // Value the override register takes on a read, based on the current mode.
    always_comb begin
        read_value = data_out_reg;
        case (state_reg)
            ST_ID: begin
                if (snes_addr[15:3] == 13'h1FE0)
                    read_value = id_rom[snes_addr[2:0]];
                else if (snes_addr[15:0] >= 16'hFF08 && snes_addr[15:0] <= 16'hFF13)
                    read_value = 8'h00;
                else
                    read_value = 8'h80;
            end
            ST_STATUS, ST_ERASE_SETUP:    read_value = 8'h80;
            ST_PROG_BUSY, ST_ERASE_BUSY:  read_value = 8'h00;
            default:                      read_value = data_out_reg;
        endcase
    end

    // Command FSM, program busy counter, erase handshake and read data register.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_ARRAY;
            cnt_reg         <= '0;
            erase_req_reg   <= 1'b0;
            erase_chip_reg  <= 1'b0;
            erase_block_reg <= '0;
            data_out_reg    <= '0;
        end else if (!use_bsx) begin
            // Block disabled: abandon any job and return to read-array.
            state_reg       <= ST_ARRAY;
            cnt_reg         <= '0;
            erase_req_reg   <= 1'b0;
            erase_chip_reg  <= 1'b0;
            erase_block_reg <= '0;
            data_out_reg    <= '0;
        end else begin
            if (rd_evt)
                data_out_reg <= read_value;

            case (state_reg)
                ST_ARRAY, ST_ID, ST_STATUS: begin
                    if (cmd_wr) begin
                        case (reg_data_in)
                            8'hFF:        state_reg <= ST_ARRAY;
                            8'h90:        state_reg <= ST_ID;
                            8'h70, 8'h71: state_reg <= ST_STATUS;
                            8'h10, 8'h40: state_reg <= ST_PROG_ARMED;
                            8'h20: begin
                                state_reg      <= ST_ERASE_SETUP;
                                erase_chip_reg <= 1'b0;
                            end
                            8'hA7: begin
                                state_reg      <= ST_ERASE_SETUP;
                                erase_chip_reg <= 1'b1;
                            end
                            default: state_reg <= state_reg;
                        endcase
                    end
                end
                ST_ERASE_SETUP: begin
                    if (cmd_wr) begin
                        if (reg_data_in == 8'hD0) begin
                            state_reg       <= ST_ERASE_BUSY;
                            erase_req_reg   <= 1'b1;
                            erase_block_reg <= snes_addr[21:16];
                        end else begin
                            state_reg <= ST_STATUS;
                        end
                    end
                end
                ST_PROG_ARMED: begin
                    // This write is the data byte; the pack commits it.
                    if (cmd_wr) begin
                        state_reg <= ST_PROG_BUSY;
                        cnt_reg   <= CNT_LOAD;
                    end
                end
                ST_PROG_BUSY: begin
                    if (cnt_reg == '0)
                        state_reg <= ST_STATUS;
                    else
                        cnt_reg <= cnt_reg - 1'b1;
                end
                ST_ERASE_BUSY: begin
                    if (erase_ack) begin
                        erase_req_reg <= 1'b0;
                        state_reg     <= ST_STATUS;
                    end
                end
                default: state_reg <= ST_ARRAY;
            endcase
        end
    end

    // use_bsx gates outputs directly so a disable takes effect in the same cycle.
    assign data_ovr       = in_flash & (state_reg != ST_ARRAY) & (state_reg != ST_PROG_ARMED);
    assign flash_writable = in_flash & (state_reg == ST_PROG_ARMED) & flash_wp_n;
    assign busy           = use_bsx & ((state_reg == ST_PROG_BUSY) | (state_reg == ST_ERASE_BUSY));
    assign erase_req      = use_bsx & erase_req_reg;
    assign erase_chip     = use_bsx & erase_chip_reg;
    assign erase_block    = use_bsx ? erase_block_reg : 6'd0;
    assign reg_data_out   = use_bsx ? data_out_reg : 8'd0;

endmodule

// File: tb/tb_bsx_flash_ctrl.sv
// Self-checking bench for bsx_flash_ctrl: read results are pushed to a
// scoreboard queue when the read strobe is driven and compared once the
// registered read data appears.
module tb_bsx_flash_ctrl;

    logic        clkin = 1'b0;
    logic        reset = 1'b1;
    logic        use_bsx = 1'b1;
    logic        flash_wp_n = 1'b1;
    logic        reg_we_rising = 1'b0;
    logic        reg_oe_falling = 1'b0;
    logic [23:0] snes_addr = 24'h000000;
    logic [7:0]  reg_data_in = 8'h00;
    logic [7:0]  reg_data_out;
    logic        data_ovr;
    logic        flash_writable;
    logic        busy;
    logic        erase_req;
    logic        erase_chip;
    logic [5:0]  erase_block;
    logic        erase_ack = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  sb_q [$];
    logic [7:0]  last_val = 8'h00;
    logic [7:0]  id_exp [8] = '{8'h4D, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h1A, 8'h00};

    bsx_flash_ctrl #(
        .PROG_BUSY_CYCLES(16),
        .ID_BYTES(64'h001A00000050004D)
    ) dut (
        .clkin(clkin),
        .reset(reset),
        .use_bsx(use_bsx),
        .flash_wp_n(flash_wp_n),
        .reg_we_rising(reg_we_rising),
        .reg_oe_falling(reg_oe_falling),
        .snes_addr(snes_addr),
        .reg_data_in(reg_data_in),
        .reg_data_out(reg_data_out),
        .data_ovr(data_ovr),
        .flash_writable(flash_writable),
        .busy(busy),
        .erase_req(erase_req),
        .erase_chip(erase_chip),
        .erase_block(erase_block),
        .erase_ack(erase_ack)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // One write cycle; flash_writable is checked while the strobe is high.
    task automatic wr(input logic [23:0] a, input logic [7:0] d, input logic exp_w);
        snes_addr     = a;
        reg_data_in   = d;
        reg_we_rising = 1'b1;
        #1;
        check($sformatf("wr %06h<=%02h writable", a, d), {31'd0, flash_writable}, {31'd0, exp_w});
        @(negedge clkin);
        reg_we_rising = 1'b0;
    endtask

    // One read cycle; expected data goes to the scoreboard, popped after the edge.
    task automatic rd(input logic [23:0] a, input logic [7:0] exp_val, input logic exp_ovr);
        logic [7:0] e;
        snes_addr      = a;
        reg_oe_falling = 1'b1;
        sb_q.push_back(exp_val);
        #1;
        check($sformatf("rd %06h ovr", a), {31'd0, data_ovr}, {31'd0, exp_ovr});
        @(negedge clkin);
        reg_oe_falling = 1'b0;
        if (sb_q.size() == 0) begin
            check("scoreboard empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("rd %06h data", a), {24'd0, reg_data_out}, {24'd0, e});
        end
        last_val = exp_val;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clkin);
    endtask

    initial begin
        // Reset state
        idle(3);
        reset = 1'b0;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst erase_req", {31'd0, erase_req}, 32'd0);
        rd(24'hC0FF00, 8'h00, 1'b0);

        // ID mode
        wr(24'hC00000, 8'h90, 1'b0);
        for (int i = 0; i < 8; i++) rd(24'hC0FF00 + 24'(i), id_exp[i], 1'b1);
        rd(24'hC0FF10, 8'h00, 1'b1);
        rd(24'hC0FF13, 8'h00, 1'b1);
        rd(24'hC0FF14, 8'h80, 1'b1);
        rd(24'hC01234, 8'h80, 1'b1);
        wr(24'hC00000, 8'hFF, 1'b0);
        rd(24'hC0FF00, last_val, 1'b0);
        // Write outside the flash window is ignored
        wr(24'h800000, 8'h90, 1'b0);
        rd(24'hC0FF00, last_val, 1'b0);

        // Program one byte
        wr(24'hC00000, 8'h40, 1'b0);
        wr(24'hC11234, 8'h5A, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("prog busy %0d", i), {31'd0, busy}, 32'd1);
            rd(24'hC10000, 8'h00, 1'b1);
        end
        check("prog done busy", {31'd0, busy}, 32'd0);
        rd(24'hC10000, 8'h80, 1'b1);
        wr(24'hC11235, 8'hA5, 1'b0);

        // Block erase
        wr(24'hC00000, 8'h20, 1'b0);
        rd(24'hC00000, 8'h80, 1'b1);
        wr(24'hC30000, 8'hD0, 1'b0);
        check("blk erase_req", {31'd0, erase_req}, 32'd1);
        check("blk erase_chip", {31'd0, erase_chip}, 32'd0);
        check("blk erase_block", {26'd0, erase_block}, 32'h03);
        check("blk busy", {31'd0, busy}, 32'd1);
        rd(24'hC30000, 8'h00, 1'b1);
        wr(24'hC30000, 8'hFF, 1'b0);
        check("blk busy after FF", {31'd0, busy}, 32'd1);
        rd(24'hC30000, 8'h00, 1'b1);
        erase_ack = 1'b1;
        @(negedge clkin);
        erase_ack = 1'b0;
        check("blk ack erase_req", {31'd0, erase_req}, 32'd0);
        check("blk ack busy", {31'd0, busy}, 32'd0);
        rd(24'hC30000, 8'h80, 1'b1);
        // Stray ack outside erase is ignored
        erase_ack = 1'b1;
        @(negedge clkin);
        erase_ack = 1'b0;
        rd(24'hC30000, 8'h80, 1'b1);

        // Aborted chip erase
        wr(24'hC00000, 8'hA7, 1'b0);
        check("abort erase_chip", {31'd0, erase_chip}, 32'd1);
        wr(24'hC00000, 8'h55, 1'b0);
        check("abort erase_req", {31'd0, erase_req}, 32'd0);
        rd(24'hC00000, 8'h80, 1'b1);

        // Chip erase, ack coincident with a write: ack wins, write ignored
        wr(24'hD50000, 8'hA7, 1'b0);
        wr(24'hD50000, 8'hD0, 1'b0);
        check("chip erase_req", {31'd0, erase_req}, 32'd1);
        check("chip erase_block", {26'd0, erase_block}, 32'h15);
        erase_ack = 1'b1;
        wr(24'hD50000, 8'hFF, 1'b0);
        erase_ack = 1'b0;
        check("chip ack erase_req", {31'd0, erase_req}, 32'd0);
        rd(24'hD50000, 8'h80, 1'b1);

        // Write-protected pack
        wr(24'hC00000, 8'hFF, 1'b0);
        flash_wp_n = 1'b0;
        wr(24'hC00000, 8'h40, 1'b0);
        wr(24'hC11234, 8'h5A, 1'b0);
        rd(24'hC11234, last_val, 1'b0);
        flash_wp_n = 1'b1;

        // use_bsx dropped mid-erase
        wr(24'hC00000, 8'h20, 1'b0);
        wr(24'hC70000, 8'hD0, 1'b0);
        check("bsx erase_req before", {31'd0, erase_req}, 32'd1);
        use_bsx = 1'b0;
        #1;
        check("bsx erase_req drop", {31'd0, erase_req}, 32'd0);
        check("bsx busy drop", {31'd0, busy}, 32'd0);
        @(negedge clkin);
        use_bsx = 1'b1;
        rd(24'hC0FF00, 8'h00, 1'b0);

        // Async reset mid-erase
        wr(24'hC00000, 8'h20, 1'b0);
        wr(24'hC30000, 8'hD0, 1'b0);
        check("rst2 erase_req before", {31'd0, erase_req}, 32'd1);
        snes_addr = 24'hC30000;
        #2;
        reset = 1'b1;
        #1;
        check("rst2 erase_req", {31'd0, erase_req}, 32'd0);
        check("rst2 busy", {31'd0, busy}, 32'd0);
        check("rst2 data_ovr", {31'd0, data_ovr}, 32'd0);
        @(negedge clkin);
        reset = 1'b0;
        rd(24'hC0FF00, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
